// File: rtl/wave_union_decoder.sv
// Wave-union carry-chain tap decoder: hit detection, ones-count fine code, coarse stamp, FWFT FIFO.
// Optional hit counter port o_hit_cnt enabled by defining WU_DEC_HIT_CNT_EN.
module wave_union_decoder #(
    parameter int unsigned NUM_TAPS   = 16,
    parameter int unsigned FINE_W     = 5,
    parameter int unsigned COARSE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [NUM_TAPS-1:0]          i_taps,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [COARSE_W+FINE_W-1:0]   o_data,
`ifdef WU_DEC_HIT_CNT_EN
    output logic [15:0]                  o_hit_cnt,
`endif
    output logic                         o_overflow
);

    localparam int unsigned DATA_W = COARSE_W + FINE_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [COARSE_W-1:0] coarse_cnt;
    logic [COARSE_W-1:0] cnt_q;
    logic [COARSE_W-1:0] coarse_r;
    logic [NUM_TAPS-1:0] tap_q;
    logic                tap_p0;
    logic                tap_v;
    logic                tap_pv;
    logic                hit;
    logic                hit_r;
    logic [FINE_W-1:0]   fine_c;
    logic [FINE_W-1:0]   fine_r;

    // Sample and stamp pipeline; tap_v/tap_pv mark that tap_q/tap_p0 hold post-reset samples
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            coarse_cnt <= '0;
            cnt_q      <= '0;
            tap_q      <= '0;
            tap_p0     <= 1'b0;
            tap_v      <= 1'b0;
            tap_pv     <= 1'b0;
            hit_r      <= 1'b0;
            fine_r     <= '0;
            coarse_r   <= '0;
        end else begin
            coarse_cnt <= coarse_cnt + COARSE_W'(1);
            cnt_q      <= coarse_cnt;
            tap_q      <= i_taps;
            tap_p0     <= tap_q[0];
            tap_v      <= 1'b1;
            tap_pv     <= tap_v;
            hit_r      <= hit;
            fine_r     <= fine_c;
            coarse_r   <= cnt_q;
        end
    end

    // Ones-count tolerates the wave-union double edge and bubbles
    always_comb begin
        fine_c = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            fine_c = fine_c + FINE_W'(tap_q[i]);
        end
    end

    assign hit = i_en & tap_pv & tap_q[0] & ~tap_p0;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] head_n;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    assign push_data = {coarse_r, fine_r};
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = o_valid & i_ready;
    assign push      = hit_r & (~full | pop);
    assign drop      = hit_r & full & ~pop;

    // Next FIFO state; head is pre-computed so o_valid/o_data come straight from flops
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        head_n   = o_data;
        if (push) begin
            wr_ptr_n = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_n = rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_n = count - CNT_W'(1);
        end
        if (count_n != '0) begin
            head_n = (push && (rd_ptr_n == wr_ptr)) ? push_data : mem[rd_ptr_n];
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            o_valid    <= (count_n != '0);
            o_data     <= head_n;
            o_overflow <= o_overflow | drop;
        end
    end

`ifdef WU_DEC_HIT_CNT_EN
    // Counts detected hits, dropped ones included; saturates
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit_cnt <= '0;
        end else if (hit && (o_hit_cnt != 16'hFFFF)) begin
            o_hit_cnt <= o_hit_cnt + 16'd1;
        end
    end
`endif

endmodule
